freq_tick_gen: RTL and testbench
================================

Name: freq_tick_gen

Overview:
- Upstream companion of the serial output stage: generates the per-bit tick stream that paces serial output of one DATA_BIT-bit frame.
- Each frame bit runs at high or low speed, selected by a per-bit speed mask latched at frame start.
- Driven with the same i_start / i_stop as the serial output stage. Its o_tick feeds the serial stage's tick input, so every output bit lasts TICK_PER_BIT ticks at the selected rate.

Parameters:
DATA_BIT, 16, bits per frame; must match the downstream serial stage.
TICK_PER_BIT, 16, ticks per bit; must match the downstream serial stage; range 1..256.
DIV_BIT, 8, width of the clock-divisor inputs.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset, asynchronous, active-high.
i_start  input  1  frame start pulse; honoured only in IDLE.
i_stop  input  1  abort; has priority over every other event.
i_repeat  input  1  sampled in DONE; 1 = reload and run the next frame with no gap.
i_speed_mask  input  DATA_BIT  per-bit speed, LSB = first bit; 1 = high speed, 0 = low speed.
i_high_div  input  DIV_BIT  clocks per tick for high-speed bits; 0 is treated as 1.
i_low_div  input  DIV_BIT  clocks per tick for low-speed bits; 0 is treated as 1.
o_tick  output  1  one-clock tick pulse to the serial stage.
o_busy  output  1  high while in RUN or DONE.
o_bit_idx  output  6  index of the bit currently being timed.
o_done_tick  output  1  one-clock pulse after the last tick of a frame.

Behaviour:
- Reset: state = IDLE; all counters = 0; mask and divisor latches = 0.
- Reset output values: o_tick = 0, o_busy = 0, o_bit_idx = 0, o_done_tick = 0.
- Reset mid-frame aborts immediately; no o_done_tick is issued.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE, i_start = 1 and i_stop = 0:
  - latch i_speed_mask, i_high_div and i_low_div;
  - clear prescaler, tick_cnt and bit_idx;
  - select the current divisor from mask[0];
  - next state RUN.
- RUN:
  - prescaler counts 0 .. div_cur-1.
  - o_tick is combinational = (state == RUN) && (prescaler == div_cur-1).
  - On a tick: prescaler returns to 0 and tick_cnt increments.
  - On a tick with tick_cnt == TICK_PER_BIT-1 (bit boundary): tick_cnt returns to 0.
    - If bit_idx == DATA_BIT-1, next state is DONE.
    - Otherwise bit_idx increments, the mask shifts right by 1, and div_cur reloads from the new mask[0] (i.e. the old mask[1]).
- Divisor handling: div_cur = max(selected divisor, 1). Divisors are latched per frame; input changes mid-frame are ignored. A divisor of 1 gives a tick every RUN cycle.
- DONE (one cycle): o_done_tick = 1, o_tick = 0.
  - If i_repeat = 1: relatch the inputs exactly as on a start and go to RUN.
  - Otherwise go to IDLE.
- i_stop = 1 in any state: next state IDLE and counters cleared; o_done_tick is not asserted.
  - In IDLE, i_stop overrides a simultaneous i_start.
  - In DONE, i_stop overrides i_repeat; o_done_tick still pulses in that DONE cycle.
- i_start in RUN or DONE is ignored.
- Timing: the first tick occurs div_cur cycles after entry to RUN. The serial stage enters its enable state on the same edge, so the bit counts stay aligned.
- Frame length in RUN = TICK_PER_BIT × (sum of div_cur over all bits) cycles.
- Widths: prescaler DIV_BIT; tick_cnt 8; bit_idx 6 (DATA_BIT ≤ 64). Counters never exceed their terminal values, so no wrap-around occurs.
- o_busy = (state != IDLE).

Test Plan:
1. Basic frame (DATA_BIT=4, TICK_PER_BIT=2, mask=4'b0101, high_div=1, low_div=3), i_start pulse:
   - RUN lasts 2·1+2·3+2·1+2·3 = 16 cycles with exactly 8 ticks;
   - tick spacing is 1,1,3,3,1,1,3,3 cycles;
   - o_bit_idx steps 0→3;
   - o_done_tick = 1 for one cycle right after the 8th tick; o_busy then falls.
2. Zero divisor: high_div=0, mask=4'hF → ticks on every RUN cycle, identical to high_div=1; frame takes 8 RUN cycles.
3. Abort: i_stop asserted after 3 ticks → IDLE next cycle; no further ticks; o_done_tick stays 0; o_bit_idx = 0.
4. Simultaneous i_start and i_stop in IDLE → state stays IDLE and no ticks appear. An i_start during RUN changes neither tick timing nor the latched mask.
5. Repeat: i_repeat = 1 during DONE, with the mask changed to 4'b1010 → RUN re-entered the next cycle with no IDLE gap; the second frame uses the new mask (first tick spacing 3); o_done_tick pulses once per frame.
6. Asynchronous reset: rst raised mid-RUN between clock edges → all outputs go to 0 immediately; after release, a fresh i_start produces a frame matching scenario 1.

Source files
------------

// File: rtl/freq_tick_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// freq_tick_gen : per-bit tick pacer for a serial output stage (high/low rate)
// Rev 1.0
// ============================================================================
module freq_tick_gen #(
    parameter int DATA_BIT     = 16,
    parameter int TICK_PER_BIT = 16,
    parameter int DIV_BIT      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_repeat,
    input  logic [DATA_BIT-1:0] i_speed_mask,
    input  logic [DIV_BIT-1:0]  i_high_div,
    input  logic [DIV_BIT-1:0]  i_low_div,
    output logic                o_tick,
    output logic                o_busy,
    output logic [5:0]          o_bit_idx,
    output logic                o_done_tick
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [DIV_BIT-1:0] c_ONE       = {{(DIV_BIT-1){1'b0}}, 1'b1};
    localparam logic [7:0]         c_TICK_LAST = 8'(TICK_PER_BIT - 1);
    localparam logic [5:0]         c_BIT_LAST  = 6'(DATA_BIT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DATA_BIT-1:0]  r_mask;
    logic [DIV_BIT-1:0]   r_high_div;
    logic [DIV_BIT-1:0]   r_low_div;
    logic [DIV_BIT-1:0]   r_div_cur;
    logic [DIV_BIT-1:0]   r_presc;
    logic [7:0]           r_tick_cnt;
    logic [5:0]           r_bit_idx;
    logic                 w_tick;
    logic                 w_load;
    logic                 w_bit_end;
    logic                 w_next_sel;

    // A zero divisor behaves like one: a tick on every RUN cycle.
    function automatic logic [DIV_BIT-1:0] eff_div(
        input logic               sel,
        input logic [DIV_BIT-1:0] hi,
        input logic [DIV_BIT-1:0] lo
    );
        logic [DIV_BIT-1:0] d;
        d = sel ? hi : lo;
        return (d == '0) ? c_ONE : d;
    endfunction

    generate
        if (DATA_BIT > 1) begin : g_next_sel_wide
            assign w_next_sel = r_mask[1];
        end else begin : g_next_sel_narrow
            assign w_next_sel = 1'b0;
        end
    endgenerate

    assign w_tick      = (r_state == S_RUN) && (r_presc == (r_div_cur - c_ONE));
    assign w_bit_end   = w_tick && (r_tick_cnt == c_TICK_LAST);
    assign o_tick      = w_tick;
    assign o_busy      = (r_state != S_IDLE);
    assign o_bit_idx   = r_bit_idx;
    assign o_done_tick = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                if (w_bit_end && (r_bit_idx == c_BIT_LAST)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_repeat) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Abort wins over start, repeat and frame completion.
        if (i_stop) begin
            w_state_nxt = S_IDLE;
            w_load      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask     <= '0;
            r_high_div <= '0;
            r_low_div  <= '0;
            r_div_cur  <= '0;
            r_presc    <= '0;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
        end else if (i_stop) begin
            r_presc    <= '0;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
        end else if (w_load) begin
            r_mask     <= i_speed_mask;
            r_high_div <= i_high_div;
            r_low_div  <= i_low_div;
            r_div_cur  <= eff_div(i_speed_mask[0], i_high_div, i_low_div);
            r_presc    <= '0;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
        end else if (r_state == S_RUN) begin
            if (w_tick) begin
                r_presc <= '0;
                if (w_bit_end) begin
                    r_tick_cnt <= '0;
                    if (r_bit_idx != c_BIT_LAST) begin
                        r_bit_idx <= r_bit_idx + 6'd1;
                        r_mask    <= r_mask >> 1;
                        r_div_cur <= eff_div(w_next_sel, r_high_div, r_low_div);
                    end
                end else begin
                    r_tick_cnt <= r_tick_cnt + 8'd1;
                end
            end else begin
                r_presc <= r_presc + c_ONE;
            end
        end else begin
            r_presc    <= '0;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_freq_tick_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_freq_tick_gen : checks freq_tick_gen against a per-cycle tick schedule
// Rev 1.0
// ============================================================================
module tb_freq_tick_gen;

    localparam int DB  = 4;
    localparam int TPB = 2;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic          i_stop;
    logic          i_repeat;
    logic [DB-1:0] i_speed_mask;
    logic [DW-1:0] i_high_div;
    logic [DW-1:0] i_low_div;
    logic          o_tick;
    logic          o_busy;
    logic [5:0]    o_bit_idx;
    logic          o_done_tick;

    int n_checks = 0;
    int n_fail   = 0;

    freq_tick_gen #(.DATA_BIT(DB), .TICK_PER_BIT(TPB), .DIV_BIT(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_repeat     (i_repeat),
        .i_speed_mask (i_speed_mask),
        .i_high_div   (i_high_div),
        .i_low_div    (i_low_div),
        .o_tick       (o_tick),
        .o_busy       (o_busy),
        .o_bit_idx    (o_bit_idx),
        .o_done_tick  (o_done_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [DB-1:0] m, input int hi, input int lo);
        i_start      = 1'b1;
        i_speed_mask = m;
        i_high_div   = DW'(hi);
        i_low_div    = DW'(lo);
        nxt();
        i_start      = 1'b0;
    endtask

    // Model: bit b lasts TPB ticks, each tick eff(div) cycles apart, the tick
    // landing on the last cycle of its interval. Ends positioned in DONE.
    task automatic check_frame(input logic [DB-1:0] m, input int hi, input int lo, input string nm);
        int ticks;
        int d;
        ticks = 0;
        for (int b = 0; b < DB; b++) begin
            d = eff(m[b] ? hi : lo);
            for (int t = 0; t < TPB; t++) begin
                for (int c = 1; c <= d; c++) begin
                    chk({nm, " tick"}, 32'(o_tick), 32'(c == d));
                    chk({nm, " bit_idx"}, 32'(o_bit_idx), 32'(b));
                    chk({nm, " busy"}, 32'(o_busy), 32'd1);
                    chk({nm, " done_early"}, 32'(o_done_tick), 32'd0);
                    if (o_tick === 1'b1) ticks++;
                    // Mid-frame input churn must not affect the latched frame.
                    i_start      = 1'($urandom % 2);
                    i_speed_mask = DB'($urandom);
                    i_high_div   = DW'($urandom);
                    i_low_div    = DW'($urandom);
                    nxt();
                end
            end
        end
        i_start = 1'b0;
        chk({nm, " tick_count"}, 32'(ticks), 32'(DB * TPB));
        chk({nm, " done_tick"}, 32'(o_done_tick), 32'd1);
        chk({nm, " done_no_tick"}, 32'(o_tick), 32'd0);
        chk({nm, " done_busy"}, 32'(o_busy), 32'd1);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, " idle_busy"}, 32'(o_busy), 32'd0);
        chk({nm, " idle_done"}, 32'(o_done_tick), 32'd0);
        chk({nm, " idle_tick"}, 32'(o_tick), 32'd0);
        chk({nm, " idle_idx"}, 32'(o_bit_idx), 32'd0);
    endtask

    initial begin
        logic [DB-1:0] m;
        int hi, lo, seen;
        bit rep;

        rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_repeat = 1'b0;
        i_speed_mask = '0; i_high_div = '0; i_low_div = '0;
        nxt(); nxt();
        check_idle("reset");
        rst = 1'b0;
        nxt();

        // Basic frame: spacing 1,1,3,3,1,1,3,3
        launch(4'b0101, 1, 3);
        check_frame(4'b0101, 1, 3, "basic");
        nxt();
        check_idle("basic_end");

        // Zero high divisor behaves as 1
        launch(4'hF, 0, 5);
        check_frame(4'hF, 0, 5, "zero_div");
        nxt();
        check_idle("zero_div_end");

        // Start and stop together in IDLE
        i_start = 1'b1; i_stop = 1'b1;
        nxt();
        i_start = 1'b0; i_stop = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_idle("start_stop");
            nxt();
        end

        // Repeat with a new mask, then repeat overridden by stop
        launch(4'b0101, 1, 3);
        check_frame(4'b0101, 1, 3, "rep1");
        i_repeat = 1'b1; i_speed_mask = 4'b1010; i_high_div = 8'd1; i_low_div = 8'd3;
        nxt();
        i_repeat = 1'b0;
        check_frame(4'b1010, 1, 3, "rep2");
        i_repeat = 1'b1; i_stop = 1'b1;
        nxt();
        i_repeat = 1'b0; i_stop = 1'b0;
        check_idle("rep_stop");
        nxt();
        check_idle("rep_stop2");

        // Abort after the third tick
        launch(4'b0101, 1, 3);
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (o_tick === 1'b1) seen++;
            if (seen == 3) break;
            nxt();
        end
        chk("abort_seen3", 32'(seen), 32'd3);
        i_stop = 1'b1;
        nxt();
        i_stop = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check_idle("abort");
            nxt();
        end

        // Randomised frames, randomly chained with repeat
        m = DB'($urandom); hi = $urandom_range(0, 4); lo = $urandom_range(0, 4);
        launch(m, hi, lo);
        for (int r = 0; r < 8; r++) begin
            check_frame(m, hi, lo, "rand");
            rep = (r < 7) ? 1'($urandom % 2) : 1'b0;
            m = DB'($urandom); hi = $urandom_range(0, 4); lo = $urandom_range(0, 4);
            i_repeat = rep; i_speed_mask = m; i_high_div = DW'(hi); i_low_div = DW'(lo);
            nxt();
            i_repeat = 1'b0;
            if (!rep) begin
                check_idle("rand_end");
                if (r < 7) launch(m, hi, lo);
            end
        end

        // Asynchronous reset mid-RUN, then a clean frame
        launch(4'b0101, 1, 3);
        repeat (5) nxt();
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        #1;
        rst = 1'b0;
        nxt();
        check_idle("post_rst");
        launch(4'b0101, 1, 3);
        check_frame(4'b0101, 1, 3, "post_rst_frame");
        nxt();
        check_idle("post_rst_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
